// File: rtl/hazard_stall_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use stall, branch flush and a freeze FSM around multi-cycle data memory accesses.
module hazard_stall_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemReqM,
  output logic             MemBusy,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount,
  output logic [1:0]       dbg_state
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_req, freeze, err_set, lw_stall;

  // M stage has priority over W; x0 is never forwarded
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM == Rs1E) && (Rs1E != 5'd0))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW == Rs1E) && (Rs1E != 5'd0)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM == Rs2E) && (Rs2E != 5'd0))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW == Rs2E) && (Rs2E != 5'd0)) ForwardBE = 2'b01;
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_req      = 1'b0;
    freeze       = 1'b0;
    err_set      = 1'b0;
    case (state)
      S_IDLE: begin
        if (MemAccessM) begin
          mem_req      = 1'b1;
          freeze       = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        freeze       = 1'b1;
        wait_cnt_nxt = wait_cnt + WCNT_W'(1);
        if (MemReadyM) begin
          state_nxt = S_RELEASE;
        end else if (wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
          err_set   = 1'b1;
          state_nxt = S_RELEASE;
        end
      end
      // the completed access is still in M here, so MemAccessM must not re-trigger
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // freeze overrides hazard handling; everything is held quiet during reset
  always_comb begin
    MemReqM = 1'b0;
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushW  = 1'b0;
    if (!rst) begin
      MemReqM = mem_req;
      StallF  = freeze | lw_stall;
      StallD  = freeze | lw_stall;
      StallE  = freeze;
      StallM  = freeze;
      FlushW  = freeze;
      FlushD  = !freeze && PCSrcE;
      FlushE  = !freeze && (lw_stall || PCSrcE);
    end
  end

  assign MemBusy   = (state == S_WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      MemErr     <= 1'b0;
      StallCount <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (err_set) MemErr <= 1'b1;
      if (StallF && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed plus randomized bench for hazard_stall_controller, checked against a
// cycle-level behavioural model of the pipeline/memory rules.
module tb_hazard_stall_controller;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemAccessM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemReqM, MemBusy, MemErr;
  logic [CNT_W-1:0] StallCount;
  logic [1:0]       dbg_state;

  hazard_stall_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemReqM(MemReqM), .MemBusy(MemBusy), .MemErr(MemErr),
    .StallCount(StallCount), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // model: m_wait = WAIT cycles elapsed on the outstanding access (-1 = none);
  // m_done = the access just completed and its instruction is still in M
  int m_wait = -1;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;
  int m_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (rs == 0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // one clock cycle: inputs already applied at the preceding negedge
  task automatic step();
    bit lw, busy, req, frz, e_stall_fd, e_fd, e_fe;
    #1;
    lw   = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    busy = (m_wait >= 0);
    req  = !rst && !busy && !m_done && MemAccessM;
    frz  = !rst && (req || busy);
    e_stall_fd = !rst && (frz || lw);
    e_fd = !rst && !frz && PCSrcE;
    e_fe = !rst && !frz && (lw || PCSrcE);
    check("ForwardAE", ForwardAE, fwd_sel(Rs1E));
    check("ForwardBE", ForwardBE, fwd_sel(Rs2E));
    check("StallF", StallF, e_stall_fd);
    check("StallD", StallD, e_stall_fd);
    check("StallE", StallE, frz);
    check("StallM", StallM, frz);
    check("FlushD", FlushD, e_fd);
    check("FlushE", FlushE, e_fe);
    check("FlushW", FlushW, frz);
    check("MemReqM", MemReqM, req);
    check("MemBusy", MemBusy, busy);
    check("MemErr", MemErr, m_err);
    check("StallCount", StallCount, m_cnt);
    @(posedge clk);
    if (rst) begin
      m_wait = -1; m_done = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (e_stall_fd && m_cnt < CNT_MAX) m_cnt++;
      if (req) begin
        m_wait = 0;
        m_done = 0;
      end else if (busy) begin
        m_wait++;
        if (MemReadyM || m_wait == MAX_WAIT) begin
          if (!MemReadyM) m_err = 1;
          m_wait = -1;
          m_done = 1;
        end
      end else begin
        m_done = 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemAccessM = 0; MemReadyM = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    step();
    step();
    rst = 0;

    // forwarding priority M over W, then W alone
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
    step();
    RegWriteM = 0;
    step();
    Rs2E = 5; Rs1E = 0;
    step();
    clear_inputs();

    // load-use hazard, then suppressed by RdE = x0
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    step();
    RdE = 0;
    step();
    RdE = 9; Rs1D = 9; Rs2D = 0;
    step();
    clear_inputs();

    // branch flush, and branch combined with load-use
    PCSrcE = 1;
    step();
    PCSrcE = 0;
    step();
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    step();
    clear_inputs();
    step();

    // memory access: ready in third WAIT cycle, branch/load-use suppressed while frozen
    MemAccessM = 1; PCSrcE = 1;
    step();
    PCSrcE = 0; ResultSrcE = 2'b01; RdE = 4; Rs2D = 4;
    step();
    step();
    MemReadyM = 1;
    step();
    MemReadyM = 0;
    step();
    MemAccessM = 0;
    step();
    clear_inputs();
    step();

    // timeout: ready never arrives
    MemAccessM = 1;
    step();
    MemAccessM = 0;
    repeat (MAX_WAIT + 3) step();
    MemReadyM = 1;
    step();
    MemReadyM = 0;
    step();

    // back-to-back accesses re-enter through IDLE
    MemAccessM = 1; MemReadyM = 1;
    repeat (7) step();
    clear_inputs();
    step();

    // reset in the second WAIT cycle drops the request
    MemAccessM = 1;
    step();
    MemAccessM = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    step();
    step();

    // saturate the stall counter with a sustained load-use
    ResultSrcE = 2'b01; RdE = 2; Rs1D = 2;
    repeat (CNT_MAX + 4) step();
    clear_inputs();
    step();

    // randomized traffic
    repeat (600) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemAccessM = ($urandom_range(0, 9) < 3);
      MemReadyM  = ($urandom_range(0, 9) < 2);
      rst        = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 0;
    clear_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
